// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size codes and the
// misalignment test used when LSU_MISALIGN_TRAP_EN is defined.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Funct3[1:0] gives the access size; 1x (010/011/110/111) is a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load lane
// extraction with sign/zero extension (Funct3[2] set = unsigned).
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  assign w_unsigned = i_funct3[2];
  assign w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15] & ~w_unsigned}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access engine: req/ready bus FSM with timeout and core stall.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        BusErr,
  output logic        MisalignErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LOAD = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_e  r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_f3;
  logic [3:0]  r_be;
  logic        r_store, r_bus_err, r_mis_err;
  logic [CW-1:0] r_cnt;

  logic        w_req, w_mis, w_timeout;
  logic [2:0]  w_f3;
  logic [1:0]  w_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep, w_rdata_ext;

  assign w_req     = MemRead | MemWrite;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == '0);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = is_misaligned(Funct3, ALUResult[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Store lanes come from the live request in IDLE; load lanes from the latched access.
  assign w_f3 = (r_state == ST_IDLE) ? Funct3 : r_f3;
  assign w_lo = (r_state == ST_IDLE) ? ALUResult[1:0] : r_addr[1:0];

  lsu_align u_align (
    .i_funct3  (w_f3),
    .i_addr_lo (w_lo),
    .i_wdata   (WriteData),
    .i_rdata   (mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    Stall   = w_req && (r_state != ST_DONE);
    mem_req = (r_state == ST_BUSY);
    case (r_state)
      ST_IDLE: if (w_req) w_next = w_mis ? ST_DONE : ST_BUSY;
      ST_BUSY: if (mem_ready || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_f3      <= '0;
      r_be      <= '0;
      r_store   <= 1'b0;
      r_bus_err <= 1'b0;
      r_mis_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_bus_err <= 1'b0;
      r_mis_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_mis) begin
              r_rdata   <= '0;
              r_mis_err <= 1'b1;
            end else begin
              r_addr  <= ALUResult;
              r_f3    <= Funct3;
              r_store <= MemWrite;
              r_be    <= w_be;
              r_wdata <= w_wdata_rep;
              r_cnt   <= TO_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            if (!r_store) r_rdata <= w_rdata_ext;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadData    = r_rdata;
  assign BusErr      = r_bus_err;
  assign MisalignErr = r_mis_err;
  assign mem_we      = r_store && (r_state == ST_BUSY);
  assign mem_addr    = {r_addr[31:2], 2'b00};
  assign mem_wdata   = r_wdata;
  assign mem_be      = r_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single-cycle-ready accesses plus
// sequences for reset abort, back-to-back, timeout, slow ready and misalignment.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, BusErr, MisalignErr;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .Stall       (Stall),
    .ReadData    (ReadData),
    .BusErr      (BusErr),
    .MisalignErr (MisalignErr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd    wr    f3      addr          wd            rdata         exp_rd        exp_addr      exp_wdata     be       we
    vt[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_0100, 32'h0,        4'b1111, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 32'h0000_0100, 32'h0,        4'b1000, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF1234, 32'h00000080, 32'h0000_0100, 32'h0,        4'b1000, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF1234, 32'h000080FF, 32'h0000_0100, 32'h0,        4'b1100, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 32'h0000_0100, 32'h0,        4'b1100, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h80FF1234, 32'h00001234, 32'h0000_0100, 32'h0,        4'b0011, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h80FF1234, 32'h00000012, 32'h0000_0100, 32'h0,        4'b0010, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_00A1, 32'h000000AB, 32'h0,        32'h00000012, 32'h0000_00A0, 32'hABABABAB, 4'b0010, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_00A2, 32'h1234CAFE, 32'h0,        32'h00000012, 32'h0000_00A0, 32'hCAFECAFE, 4'b1100, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_00A4, 32'h11223344, 32'h0,        32'h00000012, 32'h0000_00A4, 32'h11223344, 4'b1111, 1'b1};
    vt[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_00B0, 32'h55667788, 32'h99999999, 32'h00000012, 32'h0000_00B0, 32'h55667788, 4'b1111, 1'b1};
    vt[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_00C0, 32'h0,        32'h87654321, 32'h87654321, 32'h0000_00C0, 32'h0,        4'b1111, 1'b0};
    vt[12] = '{1'b1, 1'b0, 3'b100, 32'h0000_00C2, 32'h0,        32'h00AB0000, 32'h000000AB, 32'h0000_00C0, 32'h0,        4'b0100, 1'b0};
    vt[13] = '{1'b1, 1'b0, 3'b110, 32'h0000_00C4, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0000_00C4, 32'h0,        4'b1111, 1'b0};

    reset_n = 1'b0;
    idle_inputs();
    Funct3 = 3'b000; ALUResult = '0; WriteData = '0; mem_rdata = '0;
    #1;
    chk("rst_stall", 32'(Stall), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_buserr", 32'(BusErr), 32'h0);
    chk("rst_mis", 32'(MisalignErr), 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      tick();
      MemRead = vt[i].rd; MemWrite = vt[i].wr; Funct3 = vt[i].f3;
      ALUResult = vt[i].addr; WriteData = vt[i].wd; mem_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_stall_idle", i), 32'(Stall), 32'h1);
      chk($sformatf("v%0d_req_idle", i), 32'(mem_req), 32'h0);
      tick();
      chk($sformatf("v%0d_req_busy", i), 32'(mem_req), 32'h1);
      chk($sformatf("v%0d_stall_busy", i), 32'(Stall), 32'h1);
      chk($sformatf("v%0d_addr", i), mem_addr, vt[i].exp_addr);
      chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(vt[i].exp_be));
      chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].exp_wdata);
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].exp_we));
      mem_rdata = vt[i].rdata; mem_ready = 1'b1;
      tick();
      chk($sformatf("v%0d_stall_done", i), 32'(Stall), 32'h0);
      chk($sformatf("v%0d_req_done", i), 32'(mem_req), 32'h0);
      chk($sformatf("v%0d_rdata", i), ReadData, vt[i].exp_rd);
      chk($sformatf("v%0d_buserr", i), 32'(BusErr), 32'h0);
      chk($sformatf("v%0d_mis", i), 32'(MisalignErr), 32'h0);
      idle_inputs();
    end

    // Reset in the middle of a transaction, with a late ready afterwards.
    tick();
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h400; mem_ready = 1'b0;
    tick();
    chk("rab_req_busy", 32'(mem_req), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rab_req_drop", 32'(mem_req), 32'h0);
    chk("rab_rdata_clr", ReadData, 32'h0);
    MemRead = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    mem_rdata = 32'h12345678; mem_ready = 1'b1;
    #1;
    chk("rab_late_req", 32'(mem_req), 32'h0);
    tick();
    mem_ready = 1'b0;
    chk("rab_late_stall", 32'(Stall), 32'h0);
    chk("rab_late_rdata", ReadData, 32'h0);
    chk("rab_late_buserr", 32'(BusErr), 32'h0);
    tick();
    chk("rab_late_rdata2", ReadData, 32'h0);

    // Back-to-back: next store presented while the load is in DONE.
    tick();
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h200; WriteData = '0;
    #1;
    chk("b2b_stall_idle", 32'(Stall), 32'h1);
    tick();
    mem_rdata = 32'h13579BDF; mem_ready = 1'b1;
    tick();
    chk("b2b_rdata", ReadData, 32'h13579BDF);
    MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b000; ALUResult = 32'h203; WriteData = 32'h0000005A;
    mem_ready = 1'b0;
    #1;
    chk("b2b_stall_done", 32'(Stall), 32'h0);
    tick();
    chk("b2b_stall_idle2", 32'(Stall), 32'h1);
    chk("b2b_req_idle2", 32'(mem_req), 32'h0);
    tick();
    chk("b2b_req_busy2", 32'(mem_req), 32'h1);
    chk("b2b_be", 32'(mem_be), 32'h8);
    chk("b2b_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("b2b_addr", mem_addr, 32'h200);
    chk("b2b_we", 32'(mem_we), 32'h1);
    mem_ready = 1'b1;
    tick();
    chk("b2b_stall_done2", 32'(Stall), 32'h0);
    chk("b2b_rdata_kept", ReadData, 32'h13579BDF);
    idle_inputs();

    // Timeout: ready never arrives, four BUSY cycles then BusErr.
    tick();
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h300; mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_req_c%0d", k), 32'(mem_req), 32'h1);
      chk($sformatf("to_stall_c%0d", k), 32'(Stall), 32'h1);
      tick();
    end
    chk("to_buserr", 32'(BusErr), 32'h1);
    chk("to_rdata", ReadData, 32'h0);
    chk("to_stall_done", 32'(Stall), 32'h0);
    chk("to_req_done", 32'(mem_req), 32'h0);
    MemRead = 1'b0;
    tick();
    chk("to_buserr_pulse", 32'(BusErr), 32'h0);

    // Slow ready with the request dropped mid-BUSY: transaction still completes.
    tick();
    MemRead = 1'b1; Funct3 = 3'b001; ALUResult = 32'h302; mem_ready = 1'b0;
    tick();
    chk("slow_req1", 32'(mem_req), 32'h1);
    MemRead = 1'b0; mem_rdata = 32'hBEEF0000;
    tick();
    chk("slow_req2", 32'(mem_req), 32'h1);
    chk("slow_be", 32'(mem_be), 32'hC);
    tick();
    mem_ready = 1'b1;
    tick();
    chk("slow_rdata", ReadData, 32'hFFFFBEEF);
    chk("slow_buserr", 32'(BusErr), 32'h0);
    idle_inputs();

    // Misaligned word load.
    tick();
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h102; mem_ready = 1'b0; mem_rdata = 32'hAAAAAAAA;
    #1;
    chk("mis_stall_idle", 32'(Stall), 32'h1);
    chk("mis_req_idle", 32'(mem_req), 32'h0);
    tick();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req", 32'(mem_req), 32'h0);
    chk("mis_err", 32'(MisalignErr), 32'h1);
    chk("mis_rdata", ReadData, 32'h0);
    chk("mis_stall_done", 32'(Stall), 32'h0);
    MemRead = 1'b0;
    tick();
    chk("mis_err_pulse", 32'(MisalignErr), 32'h0);
    chk("mis_req_after", 32'(mem_req), 32'h0);
`else
    chk("mis_req", 32'(mem_req), 32'h1);
    chk("mis_addr", mem_addr, 32'h100);
    chk("mis_be", 32'(mem_be), 32'hF);
    mem_ready = 1'b1;
    tick();
    chk("mis_err", 32'(MisalignErr), 32'h0);
    chk("mis_rdata", ReadData, 32'hAAAAAAAA);
    chk("mis_stall_done", 32'(Stall), 32'h0);
    idle_inputs();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
